seven_seg_scan_driver: RTL

- Parametrised, time-multiplexed seven-segment display driver for the board's common-anode display.
- Scans NUM_DIGITS digits using its own refresh counter and decodes a 4-bit hex nibble per digit.
- Adds per-digit enable, leading-zero blanking, PWM brightness, and tear-free frame-synchronous data update.
- Sits between the switch/button logic and the seg/an/dp pins in the top level.

---
 rtl/seg_pkg.sv | 18 +
 rtl/hex_to_seg.sv | 11 +
 rtl/seven_seg_scan_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low hex glyphs 0..F.
  localparam seg_t HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-digit enable,
// leading-zero blanking, PWM brightness and frame-synchronous data commit.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int REFRESH_HZ  = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     en,
  input  logic                      blank_lz,
  input  logic [3:0]                bright,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame,
  output logic                      pend
);

  localparam int TICKS = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  // Scan position
  logic [TW-1:0]             tick_cnt_r;
  logic [DW-1:0]             digit_idx_r;

  // Displayed (active) and waiting (pending) buffers
  logic [4*NUM_DIGITS-1:0]   active_data_r;
  logic [NUM_DIGITS-1:0]     active_dp_r;
  logic [4*NUM_DIGITS-1:0]   pend_data_r;
  logic [NUM_DIGITS-1:0]     pend_dp_r;
  logic                      pend_r;
  logic                      frame_r;

  // Registered pin drive
  seg_t                      seg_r;
  logic                      dp_r;
  logic [NUM_DIGITS-1:0]     an_r;

  // Combinational helpers
  logic                      tick_last_s;
  logic                      boundary_s;
  logic                      commit_s;
  logic [31:0]               on_ticks_s;
  logic                      pwm_on_s;
  logic [NUM_DIGITS-1:0]     blank_mask_s;
  logic [3:0]                nibble_s;
  seg_t                      glyph_s;
  logic                      lit_s;
  seg_t                      seg_next_s;
  logic                      dp_next_s;
  logic [NUM_DIGITS-1:0]     an_next_s;

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_s),
    .seg    (glyph_s)
  );

  // Frame boundary detection and commit decision.
  always_comb begin
    tick_last_s = (tick_cnt_r == TICK_LAST);
    boundary_s  = tick_last_s && (digit_idx_r == DIGIT_LAST);
    commit_s    = boundary_s && pend_r;
  end

  // Brightness window, leading-zero mask and current digit drive.
  always_comb begin
    on_ticks_s = (32'(TICKS) * (32'(bright) + 32'd1)) >> 32'd4;
    pwm_on_s   = (32'(tick_cnt_r) < on_ticks_s);

    // A digit is blanked when it and every more-significant nibble is zero;
    // digit 0 always stays visible so a value of zero still shows "0".
    blank_mask_s = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (blank_lz && ((active_data_r >> (32'd4 * 32'(k))) == '0)) begin
        blank_mask_s[k] = 1'b1;
      end else begin
        blank_mask_s[k] = 1'b0;
      end
    end

    nibble_s = active_data_r[{digit_idx_r, 2'b00} +: 4];
    lit_s    = en[digit_idx_r] && !blank_mask_s[digit_idx_r] && pwm_on_s;

    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_next_s[k] = !(lit_s && (digit_idx_r == DW'(k)));
    end

    if (lit_s) begin
      seg_next_s = glyph_s;
      dp_next_s  = ~active_dp_r[digit_idx_r];
    end else begin
      seg_next_s = SEG_BLANK;
      dp_next_s  = 1'b1;
    end
  end

  // Tick and digit scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r  <= '0;
      digit_idx_r <= '0;
    end else if (tick_last_s) begin
      tick_cnt_r <= '0;
      if (digit_idx_r == DIGIT_LAST) begin
        digit_idx_r <= '0;
      end else begin
        digit_idx_r <= digit_idx_r + DW'(1);
      end
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Pending capture and frame-synchronous commit into the active buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_data_r <= '0;
      active_dp_r   <= '0;
      pend_data_r   <= '0;
      pend_dp_r     <= '0;
      pend_r        <= 1'b0;
      frame_r       <= 1'b0;
    end else begin
      frame_r <= commit_s;
      if (commit_s) begin
        active_data_r <= pend_data_r;
        active_dp_r   <= pend_dp_r;
      end
      // A load on the boundary itself lands in pending after the old
      // value has been committed, so pend stays set for the next frame.
      if (load) begin
        pend_data_r <= data;
        pend_dp_r   <= dp_in;
        pend_r      <= 1'b1;
      end else if (commit_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  // Registered segment, decimal point and anode outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
      an_r  <= '1;
    end else begin
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
      an_r  <= an_next_s;
    end
  end

  assign seg   = seg_r;
  assign dp    = dp_r;
  assign an    = an_r;
  assign frame = frame_r;
  assign pend  = pend_r;

endmodule
